// File: rtl/dump_pkg.sv
// Shared types and constants for the post-halt memory dump sequencer.
// Covers the FSM states, the stream framing sizes and the word-count helper.
package dump_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StRdReq,
      StRdWait,
      StSend,
      StDone
   } dump_state_e;

   localparam int unsigned HDR_BYTES  = 8;
   localparam int unsigned WORD_BYTES = 4;

   // Inclusive word count between two word-aligned addresses, clamped to max_words.
   function automatic logic [31:0] word_count(logic [31:0] base, logic [31:0] last,
                                              int unsigned max_words);
      logic [31:0] n;
      n = ((last - base) >> 2) + 32'd1;
      return (n > max_words) ? max_words : n;
   endfunction

endpackage

// File: rtl/byte_serializer.sv
// Shifts out a loaded word of up to 8 bytes, LSB first, one byte per accepted beat.
// Valid comes straight from a register, so tx_ready never reaches valid combinationally.
module byte_serializer (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clear_i,
   input  logic        load_i,
   input  logic [63:0] data_i,
   input  logic [3:0]  nbytes_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [7:0]  byte_o,
   output logic        last_o
);

   logic [63:0] shreg_q, shreg_d;
   logic [3:0]  cnt_q, cnt_d;

   assign valid_o = (cnt_q != 4'd0);
   assign byte_o  = shreg_q[7:0];
   assign last_o  = (cnt_q == 4'd1);

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else if (load_i) begin
         shreg_d = data_i;
         cnt_d   = nbytes_i;
      end else if (valid_o && ready_i) begin
         // Zero fill keeps byte_o at 0 once the word is drained.
         shreg_d = {8'h00, shreg_q[63:8]};
         cnt_d   = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_dump_sequencer.sv
// Dumps the tracker-reported written range of data memory as a byte stream:
// an 8-byte header (base, count) followed by each word, LSB first.
module mem_dump_sequencer
   import dump_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [ADDR_W-1:0] min_addr_i,
   input  logic [ADDR_W-1:0] max_addr_i,
   output logic              mem_sel_o,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [31:0]       rd_data_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic              busy_o,
   output logic              done_o
);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       count_q, count_d;
   logic [31:0]       idx_q, idx_d;

   logic [ADDR_W-1:0] start_base, start_last;
   logic [31:0]       start_count;

   logic              ser_load, ser_clear, ser_last, ser_accept;
   logic [63:0]       ser_data;
   logic [3:0]        ser_nbytes;

   // An inverted range is the tracker's "nothing written" encoding.
   always_comb begin
      start_base  = '0;
      start_last  = '0;
      start_count = '0;
      if (min_addr_i <= max_addr_i) begin
         start_base  = {min_addr_i[ADDR_W-1:2], 2'b00};
         start_last  = {max_addr_i[ADDR_W-1:2], 2'b00};
         start_count = word_count(32'(start_base), 32'(start_last), MAX_WORDS);
      end
   end

   assign ser_accept = tx_valid_o && tx_ready_i;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      idx_d      = idx_q;
      ser_load   = 1'b0;
      ser_clear  = 1'b0;
      ser_data   = {32'h0, rd_data_i};
      ser_nbytes = 4'(WORD_BYTES);

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               base_d     = start_base;
               count_d    = start_count;
               idx_d      = '0;
               ser_load   = 1'b1;
               ser_data   = {start_count, 32'(start_base)};
               ser_nbytes = 4'(HDR_BYTES);
               state_d    = StHdr;
            end
         end
         StHdr: begin
            if (ser_accept && ser_last) begin
               state_d = (count_q == 32'd0) ? StDone : StRdReq;
            end
         end
         StRdReq: begin
            state_d = StRdWait;
         end
         StRdWait: begin
            ser_load = 1'b1;
            state_d  = StSend;
         end
         StSend: begin
            if (ser_accept && ser_last) begin
               if (idx_q == count_q - 32'd1) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 32'd1;
                  state_d = StRdReq;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (abort_i && (state_q != StIdle)) begin
         state_d   = StIdle;
         ser_load  = 1'b0;
         ser_clear = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         count_q <= count_d;
         idx_q   <= idx_d;
      end
   end

   assign busy_o    = (state_q != StIdle);
   assign mem_sel_o = (state_q != StIdle);
   assign rd_en_o   = (state_q == StRdReq);
   assign done_o    = (state_q == StDone);
   assign rd_addr_o = rd_en_o ? (base_q + ADDR_W'({idx_q, 2'b00})) : '0;

   byte_serializer u_ser (
      .clk_i    (clk),
      .reset_i  (reset_i),
      .clear_i  (ser_clear),
      .load_i   (ser_load),
      .data_i   (ser_data),
      .nbytes_i (ser_nbytes),
      .ready_i  (tx_ready_i),
      .valid_o  (tx_valid_o),
      .byte_o   (tx_data_o),
      .last_o   (ser_last)
   );

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Self-checking bench for mem_dump_sequencer: directed and randomized dumps checked
// against a byte/address model built from the range rules.
module tb_mem_dump_sequencer;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic        abort_i;
   logic [31:0] min_addr_i;
   logic [31:0] max_addr_i;
   logic        mem_sel_o;
   logic        rd_en_o;
   logic [31:0] rd_addr_o;
   logic [31:0] rd_data_i;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   mem_dump_sequencer #(
      .ADDR_W    (32),
      .MAX_WORDS (1024)
   ) dut (
      .clk        (clk),
      .reset_i    (reset_i),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .min_addr_i (min_addr_i),
      .max_addr_i (max_addr_i),
      .mem_sel_o  (mem_sel_o),
      .rd_en_o    (rd_en_o),
      .rd_addr_o  (rd_addr_o),
      .rd_data_i  (rd_data_i),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   function automatic logic [31:0] mem_word(logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   // Memory answers one cycle after the strobe; garbage otherwise exposes timing slips.
   always @(posedge clk) begin
      rd_data_i <= rd_en_o ? mem_word(rd_addr_o) : $urandom();
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_dump(input logic [31:0] mn, input logic [31:0] mx, input int ready_pct,
                           input int abort_at, input int budget);
      logic [31:0] b, l, c, a, d;
      logic [7:0]  exp_b[$];
      logic [31:0] exp_a[$];
      int          accepted, reads;
      logic        seen_done, aborted, prev_valid, prev_ready;
      logic [7:0]  prev_data;

      if (mn > mx) begin
         b = 32'h0;
         c = 32'h0;
      end else begin
         b = mn & 32'hFFFF_FFFC;
         l = mx & 32'hFFFF_FFFC;
         c = (l - b) / 4 + 1;
         if (c > 32'd1024) c = 32'd1024;
      end
      for (int i = 0; i < 4; i++) exp_b.push_back(8'(b >> (8 * i)));
      for (int i = 0; i < 4; i++) exp_b.push_back(8'(c >> (8 * i)));
      for (int w = 0; w < int'(c); w++) begin
         a = b + 32'(4 * w);
         exp_a.push_back(a);
         d = mem_word(a);
         for (int i = 0; i < 4; i++) exp_b.push_back(8'(d >> (8 * i)));
      end

      @(negedge clk);
      min_addr_i = mn;
      max_addr_i = mx;
      start_i    = 1'b1;
      tx_ready_i = 1'b0;
      accepted   = 0;
      reads      = 0;
      seen_done  = 1'b0;
      aborted    = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = 8'h0;

      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         abort_i = 1'b0;
         if (aborted) begin
            start_i = 1'b0;
            chk("abort_busy", 32'(busy_o), 32'd0);
            chk("abort_mem_sel", 32'(mem_sel_o), 32'd0);
            chk("abort_tx_valid", 32'(tx_valid_o), 32'd0);
            chk("abort_rd_en", 32'(rd_en_o), 32'd0);
            chk("abort_done", 32'(done_o), 32'd0);
            repeat (5) begin
               @(negedge clk);
               chk("abort_no_done", 32'(done_o), 32'd0);
               chk("abort_no_read", 32'(rd_en_o), 32'd0);
            end
            break;
         end
         if (done_o) begin
            start_i   = 1'b0;
            seen_done = 1'b1;
            chk("done_busy", 32'(busy_o), 32'd1);
            chk("done_tx_valid", 32'(tx_valid_o), 32'd0);
            chk("done_bytes", 32'(accepted), 32'(exp_b.size()));
            chk("done_reads", 32'(reads), c);
            break;
         end
         chk("busy", 32'(busy_o), 32'd1);
         chk("mem_sel", 32'(mem_sel_o), 32'd1);
         if (rd_en_o) begin
            if (reads < exp_a.size()) chk("rd_addr", rd_addr_o, exp_a[reads]);
            reads++;
         end
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", 32'(tx_valid_o), 32'd1);
            chk("hold_data", 32'(tx_data_o), 32'(prev_data));
         end
         start_i    = ($urandom_range(7, 0) == 0);
         min_addr_i = $urandom();
         max_addr_i = $urandom();
         tx_ready_i = (int'($urandom_range(99, 0)) < ready_pct);
         if (abort_at >= 0 && accepted == abort_at) begin
            chk("abort_in_send", 32'(tx_valid_o), 32'd1);
            tx_ready_i = 1'b0;
            abort_i    = 1'b1;
            aborted    = 1'b1;
         end
         if (tx_valid_o && tx_ready_i) begin
            if (accepted < exp_b.size()) chk("tx_byte", 32'(tx_data_o), 32'(exp_b[accepted]));
            accepted++;
         end
         prev_valid = tx_valid_o;
         prev_ready = tx_ready_i;
         prev_data  = tx_data_o;
      end

      if (!aborted) begin
         chk("done_seen", 32'(seen_done), 32'd1);
         @(negedge clk);
         chk("idle_busy", 32'(busy_o), 32'd0);
         chk("idle_mem_sel", 32'(mem_sel_o), 32'd0);
         chk("done_one_cycle", 32'(done_o), 32'd0);
         chk("idle_tx_valid", 32'(tx_valid_o), 32'd0);
      end
      abort_i = 1'b0;
      start_i = 1'b0;
   endtask

   initial begin
      logic [31:0] mn, mx;
      reset_i    = 1'b1;
      start_i    = 1'b0;
      abort_i    = 1'b0;
      min_addr_i = 32'h0;
      max_addr_i = 32'h0;
      tx_ready_i = 1'b0;
      #1;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_mem_sel", 32'(mem_sel_o), 32'd0);
      chk("rst_rd_en", 32'(rd_en_o), 32'd0);
      chk("rst_rd_addr", rd_addr_o, 32'd0);
      chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
      chk("rst_tx_data", 32'(tx_data_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      repeat (3) @(negedge clk);
      reset_i = 1'b0;

      // Four-word range, sink always ready.
      for (int i = 0; i < 4; i++) mem[32'h10 + 32'(4 * i)] = $urandom();
      run_dump(32'h10, 32'h1C, 100, -1, 200);

      // Tracker reset values: header only.
      run_dump(32'hFFFF_FFFF, 32'h0, 100, -1, 100);

      // Unaligned single byte collapses to one word.
      run_dump(32'h13, 32'h13, 100, -1, 100);

      // Backpressure with randomized ready.
      run_dump(32'h104, 32'h12B, 40, -1, 2000);

      // Abort while sending word index 2.
      run_dump(32'h100, 32'h11C, 100, 17, 500);

      // Saturation at the word clamp.
      run_dump(32'h0, 32'h2000, 100, -1, 7000);

      for (int t = 0; t < 4; t++) begin
         mn = $urandom_range(32'h3FFF, 0);
         mx = mn + $urandom_range(48, 0);
         run_dump(mn, mx, 50, -1, 2000);
      end
      mn = $urandom() | 32'h8000_0000;
      mx = $urandom_range(32'h7FFF_FFFF, 0);
      run_dump(mn, mx, 50, -1, 500);

      // Reset in the middle of a dump abandons it.
      @(negedge clk);
      min_addr_i = 32'h200;
      max_addr_i = 32'h23C;
      start_i    = 1'b1;
      tx_ready_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (15) @(negedge clk);
      #2 reset_i = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_mem_sel", 32'(mem_sel_o), 32'd0);
      chk("midrst_tx_valid", 32'(tx_valid_o), 32'd0);
      chk("midrst_rd_en", 32'(rd_en_o), 32'd0);
      chk("midrst_done", 32'(done_o), 32'd0);
      @(negedge clk);
      reset_i = 1'b0;
      run_dump(32'h40, 32'h4C, 100, -1, 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
